// File: rtl/irq_pkg.sv
// Shared constants for the interrupt request front end.
// Line indices name the three CPU interrupt inputs.
package irq_pkg;

    localparam int IRQ_N_DEFAULT = 3;
    localparam int DROP_CNT_W    = 8;
    localparam int DROP_SUM_W    = DROP_CNT_W + 1;

    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 8'hFF;

    localparam int IRQ_LINE0 = 0;
    localparam int IRQ_LINE1 = 1;
    localparam int IRQ_LINE2 = 2;

endpackage

// File: rtl/irq_line_cond.sv
// One interrupt line's conditioning: synchroniser, debouncer and rising-edge event.
// rise_o pulses in the cycle whose edge moves the debounced level from 0 to 1.
module irq_line_cond
    import irq_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw_i,
    output logic rise_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   deb_q, deb_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    assign synced = sync_q[SYNC_STAGES-1];

    // The level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        if (synced == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            deb_d = synced;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            deb_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], key_raw_i};
            deb_q  <= deb_d;
            cnt_q  <= cnt_d;
        end
    end

    assign rise_o = deb_d & ~deb_q;

endmodule

// File: rtl/irq_request_ctrl.sv
// Interrupt request front end: latches debounced key presses as pending IRQs,
// clears them on a rising IRW acknowledge and counts requests merged into a pending line.
module irq_request_ctrl
    import irq_pkg::*;
#(
    parameter int N_IRQ           = IRQ_N_DEFAULT,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_IRQ-1:0]      key_raw,
    input  logic [N_IRQ-1:0]      irq_en,
    input  logic [N_IRQ-1:0]      IRW,
    input  logic                  drop_clr,
    output logic [N_IRQ-1:0]      IRQ,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    logic [N_IRQ-1:0]      rise;
    logic [N_IRQ-1:0]      req;
    logic [N_IRQ-1:0]      ack;
    logic [N_IRQ-1:0]      dropVec;
    logic [N_IRQ-1:0]      irq_q, irq_d;
    logic [N_IRQ-1:0]      irw_q;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;
    logic [DROP_SUM_W-1:0] dropInc;
    logic [DROP_SUM_W-1:0] dropSum;

    for (genvar g = 0; g < N_IRQ; g++) begin : gLine
        irq_line_cond #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cond (
            .clk      (clk),
            .rst      (rst),
            .key_raw_i(key_raw[g]),
            .rise_o   (rise[g])
        );
    end

    assign req = rise & irq_en;
    assign ack = IRW & ~irw_q;

    // A new request outranks a same-cycle ack so the fresh event is never lost.
    always_comb begin
        irq_d   = irq_q;
        dropVec = '0;
        dropInc = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (!irq_en[i]) begin
                irq_d[i] = 1'b0;
            end else if (req[i]) begin
                irq_d[i] = 1'b1;
            end else if (ack[i]) begin
                irq_d[i] = 1'b0;
            end
            dropVec[i] = req[i] & irq_q[i] & ~ack[i];
            dropInc    = dropInc + DROP_SUM_W'(dropVec[i]);
        end
    end

    assign dropSum = {1'b0, drop_q} + dropInc;

    always_comb begin
        drop_d = drop_q;
        if (drop_clr) begin
            drop_d = '0;
        end else if (dropSum > {1'b0, DROP_CNT_MAX}) begin
            drop_d = DROP_CNT_MAX;
        end else begin
            drop_d = dropSum[DROP_CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_q  <= '0;
            irw_q  <= '0;
            drop_q <= '0;
        end else begin
            irq_q  <= irq_d;
            irw_q  <= IRW;
            drop_q <= drop_d;
        end
    end

    assign IRQ      = irq_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_irq_request_ctrl.sv
// Directed bench for irq_request_ctrl with hand-computed IRQ and drop_cnt values.
// Inputs change 1 time unit after a rising edge; outputs are read at the same point.
module tb_irq_request_ctrl;
    import irq_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] key_raw;
    logic [2:0] irq_en;
    logic [2:0] IRW;
    logic       drop_clr;
    logic [2:0] IRQ;
    logic [7:0] drop_cnt;

    int checkCount = 0;
    int passCount  = 0;

    irq_request_ctrl #(
        .N_IRQ          (3),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .key_raw (key_raw),
        .irq_en  (irq_en),
        .IRW     (IRW),
        .drop_clr(drop_clr),
        .IRQ     (IRQ),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] key, input logic [2:0] en,
                                 input logic [2:0] irw, input logic clr);
        key_raw  = key;
        irq_en   = en;
        IRW      = irw;
        drop_clr = clr;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Release all keys until they debounce low, then press the given set.
    task automatic repress(input logic [2:0] held, input logic [2:0] pressed);
        applyStimulus(held, irq_en, IRW, 1'b0);
        tick(8);
        applyStimulus(held | pressed, irq_en, IRW, 1'b0);
        tick(6);
    endtask

    initial begin
        logic [2:0] line0Mask;
        line0Mask = '0;
        line0Mask[IRQ_LINE0] = 1'b1;

        rst = 1'b0;
        applyStimulus(3'b000, 3'b111, 3'b000, 1'b0);
        tick(2);
        rst = 1'b1;
        checkOutput("reset_irq", 32'(IRQ), 32'h0);
        checkOutput("reset_drop", 32'(drop_cnt), 32'h0);

        applyStimulus(line0Mask, 3'b111, 3'b000, 1'b0);
        tick(5);
        checkOutput("key0_before_latency", 32'(IRQ), 32'h0);
        tick(1);
        checkOutput("key0_at_latency", 32'(IRQ), 32'h1);
        checkOutput("key0_drop", 32'(drop_cnt), 32'h0);
        tick(14);
        checkOutput("key0_held", 32'(IRQ), 32'h1);

        applyStimulus(3'b011, 3'b111, 3'b000, 1'b0);
        tick(3);
        applyStimulus(3'b001, 3'b111, 3'b000, 1'b0);
        tick(10);
        checkOutput("glitch_key1", 32'(IRQ), 32'h1);

        applyStimulus(3'b101, 3'b111, 3'b000, 1'b0);
        tick(6);
        checkOutput("key2_pending", 32'(IRQ), 32'h5);
        applyStimulus(3'b101, 3'b111, 3'b100, 1'b0);
        tick(1);
        checkOutput("ack2_clears", 32'(IRQ), 32'h1);
        tick(9);
        checkOutput("ack2_held_no_reassert", 32'(IRQ), 32'h1);
        repress(3'b001, 3'b100);
        checkOutput("irw_held_no_reack", 32'(IRQ), 32'h5);
        tick(3);
        checkOutput("irw_held_stays", 32'(IRQ), 32'h5);
        applyStimulus(3'b101, 3'b111, 3'b000, 1'b0);
        tick(1);

        applyStimulus(3'b100, 3'b111, 3'b000, 1'b0);
        tick(8);
        checkOutput("key0_fall_no_event", 32'(IRQ), 32'h5);
        applyStimulus(3'b101, 3'b111, 3'b000, 1'b0);
        tick(5);
        applyStimulus(3'b101, 3'b111, 3'b001, 1'b0);
        tick(1);
        checkOutput("req_beats_ack_irq", 32'(IRQ), 32'h5);
        checkOutput("req_beats_ack_drop", 32'(drop_cnt), 32'h0);
        applyStimulus(3'b101, 3'b111, 3'b000, 1'b0);
        tick(1);
        checkOutput("irw_fall_no_effect", 32'(IRQ), 32'h5);

        applyStimulus(3'b101, 3'b111, 3'b010, 1'b0);
        tick(2);
        applyStimulus(3'b101, 3'b111, 3'b000, 1'b0);
        checkOutput("ack_nonpending_irq", 32'(IRQ), 32'h5);
        checkOutput("ack_nonpending_drop", 32'(drop_cnt), 32'h0);

        applyStimulus(3'b111, 3'b111, 3'b000, 1'b0);
        tick(6);
        checkOutput("all_pending", 32'(IRQ), 32'h7);
        checkOutput("all_pending_drop", 32'(drop_cnt), 32'h0);
        repress(3'b000, 3'b111);
        checkOutput("drop_three", 32'(drop_cnt), 32'd3);
        for (int i = 1; i < 84; i++) repress(3'b000, 3'b111);
        checkOutput("drop_252", 32'(drop_cnt), 32'd252);
        repress(3'b110, 3'b001);
        repress(3'b110, 3'b001);
        checkOutput("drop_254", 32'(drop_cnt), 32'd254);
        repress(3'b000, 3'b111);
        checkOutput("drop_saturates", 32'(drop_cnt), 32'd255);
        for (int i = 85; i < 90; i++) repress(3'b000, 3'b111);
        checkOutput("drop_stays_saturated", 32'(drop_cnt), 32'd255);
        checkOutput("drop_irq_merged", 32'(IRQ), 32'h7);

        applyStimulus(3'b000, 3'b111, 3'b000, 1'b0);
        tick(8);
        applyStimulus(3'b111, 3'b111, 3'b000, 1'b0);
        tick(5);
        applyStimulus(3'b111, 3'b111, 3'b000, 1'b1);
        tick(1);
        applyStimulus(3'b111, 3'b111, 3'b000, 1'b0);
        checkOutput("clr_wins_over_drops", 32'(drop_cnt), 32'h0);
        tick(1);
        checkOutput("clr_after", 32'(drop_cnt), 32'h0);

        applyStimulus(3'b111, 3'b101, 3'b000, 1'b0);
        tick(1);
        checkOutput("disable_clears_line1", 32'(IRQ), 32'h5);
        repress(3'b101, 3'b010);
        tick(4);
        checkOutput("disabled_no_request", 32'(IRQ), 32'h5);
        checkOutput("disabled_no_drop", 32'(drop_cnt), 32'h0);
        repress(3'b010, 3'b101);
        checkOutput("pre_reset_drop", 32'(drop_cnt), 32'd2);
        checkOutput("pre_reset_irq", 32'(IRQ), 32'h5);

        #3;
        rst = 1'b0;
        #1;
        checkOutput("async_reset_irq", 32'(IRQ), 32'h0);
        checkOutput("async_reset_drop", 32'(drop_cnt), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        applyStimulus(3'b111, 3'b111, 3'b000, 1'b0);
        tick(5);
        checkOutput("held_key_no_replay", 32'(IRQ), 32'h0);
        tick(1);
        checkOutput("held_key_after_release", 32'(IRQ), 32'h7);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
